// File: rtl/prefix_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prefix_counter_pkg
//  Description : Shared types and constants for the prefix_counter block.
//                cnt_dir_e      - count direction as seen on down_i
//                Speed*         - prefix-tree selector values for 'speed'
//  Revision    : 1.0  initial release
// ============================================================================
package prefix_counter_pkg;

  typedef enum logic {
    CntUp   = 1'b0,
    CntDown = 1'b1
  } cnt_dir_e;

  localparam int unsigned SpeedSerial = 0;  // ripple AND chain
  localparam int unsigned SpeedMedium = 1;  // Brent-Kung
  localparam int unsigned SpeedFast   = 2;  // Sklansky

endpackage
`default_nettype wire

// File: rtl/prefix_counter_inc_dec.sv
`default_nettype none
// ============================================================================
//  Module      : inc_dec
//  Description : Combinational +/-1 datapath built on a parallel-prefix AND.
//                The operand is inverted for down counts so a single prefix
//                tree serves both directions; the result is inverted back.
//  Ports       : A        in  width  operand
//                down     in  1      0: A+1, 1: A-1
//                Z        out width  result (wraps modulo 2**width)
//                at_bound out 1      operand sits at the terminal value for
//                                    the selected direction
//  Revision    : 1.0  initial release
// ============================================================================
module inc_dec
  import prefix_counter_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned speed = SpeedMedium
) (
  input  logic [width-1:0] A,
  input  logic             down,
  output logic [width-1:0] Z,
  output logic             at_bound
);

  localparam int Levels = $clog2(width);

  // Ripple chain: po[i] = &a[i:0].
  function automatic logic [width-1:0] pa_serial(input logic [width-1:0] a);
    logic [width-1:0] p;
    p = a;
    for (int i = 1; i < width; i++) p[i] = p[i-1] & a[i];
    return p;
  endfunction

  // Brent-Kung: an up-sweep builds power-of-two spans ending at 2^k-1
  // positions, then a down-sweep fills the remaining bits.
  function automatic logic [width-1:0] pa_brent_kung(input logic [width-1:0] a);
    logic [width-1:0] p;
    int j;
    p = a;
    for (int l = 0; (2 << l) <= width; l++) begin
      for (int i = 0; i < width; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          j = i - (1 << l);
          if (j < 0) j = 0;
          p[i] = p[i] & p[j];
        end
      end
    end
    for (int l = Levels - 1; l >= 0; l--) begin
      for (int i = 0; i < width; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
          j = i - (1 << l);
          if (j < 0) j = 0;
          p[i] = p[i] & p[j];
        end
      end
    end
    return p;
  endfunction

  // Sklansky: at level l every bit with index bit l set combines with the
  // last bit of the preceding aligned 2^l block.
  function automatic logic [width-1:0] pa_sklansky(input logic [width-1:0] a);
    logic [width-1:0] p;
    int j;
    p = a;
    for (int l = 0; l < Levels; l++) begin
      for (int i = 0; i < width; i++) begin
        if (((i >> l) & 1) == 1) begin
          j = ((i >> l) << l) - 1;
          if (j < 0) j = 0;
          p[i] = p[i] & p[j];
        end
      end
    end
    return p;
  endfunction

  cnt_dir_e         dir;
  logic [width-1:0] opnd;
  logic [width-1:0] po;
  logic [width-1:0] inc;

  assign dir  = cnt_dir_e'(down);
  assign opnd = (dir == CntDown) ? ~A : A;

  if (speed == SpeedSerial) begin : g_serial
    assign po = pa_serial(opnd);
  end else if (speed == SpeedMedium) begin : g_brent_kung
    assign po = pa_brent_kung(opnd);
  end else if (speed == SpeedFast) begin : g_sklansky
    assign po = pa_sklansky(opnd);
  end else begin : g_bad_speed
    $error("inc_dec: speed must be 0, 1 or 2");
    assign po = pa_serial(opnd);
  end

  // Bit i toggles when all lower bits are ones.
  assign inc      = opnd ^ {po[width-2:0], 1'b1};
  assign Z        = (dir == CntDown) ? ~inc : inc;
  assign at_bound = po[width-1];

endmodule
`default_nettype wire

// File: rtl/prefix_counter.sv
`default_nettype none
// ============================================================================
//  Module      : prefix_counter
//  Description : Loadable up/down counter with wrap or saturate behaviour and
//                a registered overflow pulse. Priority clr > load > enable.
//  Ports       : clk_i   in  1      clock, rising edge
//                rst_ni  in  1      asynchronous reset, active low
//                clr_i   in  1      synchronous clear to init
//                load_i  in  1      synchronous load of d_i
//                d_i     in  width  load value
//                en_i    in  1      count enable
//                down_i  in  1      0: up, 1: down
//                q_o     out width  counter value (register output)
//                tc_o    out 1      terminal count for the current direction
//                ovf_o   out 1      one-cycle pulse after a boundary step
//  Revision    : 1.0  initial release
// ============================================================================
module prefix_counter
  import prefix_counter_pkg::*;
#(
  parameter int unsigned     width    = 8,
  parameter int unsigned     speed    = SpeedMedium,
  parameter int unsigned     saturate = 0,
  parameter logic [width-1:0] init    = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [width-1:0] d_i,
  input  logic             en_i,
  input  logic             down_i,
  output logic [width-1:0] q_o,
  output logic             tc_o,
  output logic             ovf_o
);

  if (width < 2) begin : g_bad_width
    $error("prefix_counter: width must be at least 2");
  end

  logic [width-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [width-1:0] step;
  logic             at_bound;

  inc_dec #(
    .width(width),
    .speed(speed)
  ) u_inc_dec (
    .A       (q_q),
    .down    (down_i),
    .Z       (step),
    .at_bound(at_bound)
  );

  // d_i and down_i only reach q_d on the branches that use them, so X on
  // an unused input cannot leak into the register.
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (clr_i) begin
      q_d = init;
    end else if (load_i) begin
      q_d = d_i;
    end else if (en_i) begin
      ovf_d = at_bound;
      // In saturate mode a boundary step keeps the current (bound) value.
      if (!((saturate != 0) && at_bound)) q_d = step;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q   <= init;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q_o   = q_q;
  assign ovf_o = ovf_q;
  assign tc_o  = at_bound;

endmodule
`default_nettype wire

// File: tb/tb_prefix_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prefix_counter
//  Description : Scoreboard bench for prefix_counter over several widths,
//                speeds, saturate modes and init values sharing one stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prefix_counter;

  localparam int NCFG = 12;

  // {width, speed, saturate, init}
  function automatic logic [39:0] cfg(input int i);
    case (i)
      0:       return {8'd4,  8'd0, 8'd0, 16'h0000};
      1:       return {8'd4,  8'd1, 8'd0, 16'h0000};
      2:       return {8'd4,  8'd2, 8'd0, 16'h0000};
      3:       return {8'd4,  8'd0, 8'd1, 16'h0005};
      4:       return {8'd4,  8'd1, 8'd1, 16'h0005};
      5:       return {8'd4,  8'd2, 8'd1, 16'h0005};
      6:       return {8'd2,  8'd0, 8'd0, 16'h0000};
      7:       return {8'd5,  8'd1, 8'd1, 16'h0003};
      8:       return {8'd16, 8'd2, 8'd0, 16'h1234};
      9:       return {8'd16, 8'd0, 8'd1, 16'h0000};
      10:      return {8'd5,  8'd2, 8'd0, 16'h0000};
      default: return {8'd2,  8'd1, 8'd1, 16'h0001};
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, load, en, down;
  logic [15:0] d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst,
                     input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h, expected %h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam logic [39:0] C    = cfg(gi);
    localparam int          W    = int'(C[39:32]);
    localparam int          S    = int'(C[31:24]);
    localparam int          SAT  = int'(C[23:16]);
    localparam logic [15:0] MASK = 16'((32'd1 << W) - 1);
    localparam logic [15:0] INIT = C[15:0] & MASK;

    logic [W-1:0] q_w;
    logic         tc_w, ovf_w;
    logic [15:0]  q_ext;
    logic [16:0]  m_st;
    logic [16:0]  sbq[$];

    assign q_ext = 16'(q_w);

    prefix_counter #(
      .width   (W),
      .speed   (S),
      .saturate(SAT),
      .init    (INIT[W-1:0])
    ) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .clr_i (clr),
      .load_i(load),
      .d_i   (d[W-1:0]),
      .en_i  (en),
      .down_i(down),
      .q_o   (q_w),
      .tc_o  (tc_w),
      .ovf_o (ovf_w)
    );

    // Reference: arithmetic counter modulo 2**W, clamped when SAT is set.
    function automatic logic [16:0] nxt(input logic [15:0] cq, input logic c,
                                        input logic l, input logic e,
                                        input logic dn, input logic [15:0] dv);
      logic [15:0] nq;
      logic        ov;
      nq = cq;
      ov = 1'b0;
      if (c) nq = INIT;
      else if (l) nq = dv & MASK;
      else if (e) begin
        if (!dn) begin
          if (cq == MASK) begin
            ov = 1'b1;
            nq = (SAT != 0) ? MASK : 16'h0000;
          end else nq = cq + 16'd1;
        end else begin
          if (cq == 16'h0000) begin
            ov = 1'b1;
            nq = (SAT != 0) ? 16'h0000 : MASK;
          end else nq = cq - 16'd1;
        end
      end
      return {ov, nq};
    endfunction

    // Stimulus side: every edge pushes the expected post-edge state.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_st <= {1'b0, INIT};
        sbq.delete();
      end else begin
        sbq.push_back(nxt(m_st[15:0], clr, load, en, down, d));
        m_st <= nxt(m_st[15:0], clr, load, en, down, d);
      end
    end

    // Monitor side: the counter presents a value every cycle.
    always @(negedge clk) begin
      if (!rst_n) begin
        chk("reset_q", gi, q_ext, INIT);
        chk("reset_ovf", gi, 16'(ovf_w), 16'h0);
      end else if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty inst%0d: got no expected entry, required one at %0t",
                 gi, $time);
      end else begin
        chk("q", gi, q_ext, {1'b0, sbq[0][15:0]});
        chk("ovf", gi, 16'(ovf_w), 16'(sbq[0][16]));
        if (down !== 1'bx)
          chk("tc", gi, 16'(tc_w),
              16'(down ? (sbq[0][15:0] == 16'h0) : (sbq[0][15:0] == MASK)));
        sbq.delete(0);
      end
    end

    // Asynchronous reset must take effect without a clock edge.
    always @(negedge rst_n) begin
      #1;
      chk("async_reset_q", gi, q_ext, INIT);
      chk("async_reset_ovf", gi, 16'(ovf_w), 16'h0);
    end
  end

  task automatic drive(input logic c, input logic l, input logic e,
                       input logic dn, input logic [15:0] dv);
    @(negedge clk);
    #1;
    clr  = c;
    load = l;
    en   = e;
    down = dn;
    d    = dv;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Directed checks against constants on a wrap instance (0) and a
  // saturating instance with init=5 (3), both width 4.
  task automatic dchk(input string nm, input logic [3:0] q0, input logic o0,
                      input logic [3:0] q3, input logic o3);
    chk({nm, "_q"},   0, g_dut[0].q_ext, {12'h0, q0});
    chk({nm, "_ovf"}, 0, 16'(g_dut[0].ovf_w), 16'(o0));
    chk({nm, "_q"},   3, g_dut[3].q_ext, {12'h0, q3});
    chk({nm, "_ovf"}, 3, 16'(g_dut[3].ovf_w), 16'(o3));
  endtask

  initial begin
    logic [15:0] dv;
    int          r;
    clr = 1'b0; load = 1'b0; en = 1'b0; down = 1'b0; d = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of counting from 9.
    drive(0, 1, 0, 0, 16'h0009); after_edge();
    dchk("load9", 4'h9, 1'b0, 4'h9, 1'b0);
    drive(0, 0, 0, 0, 16'h0000);
    rst_n = 1'b0;
    #2;
    dchk("rst_mid", 4'h0, 1'b0, 4'h5, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Clear to init.
    drive(0, 1, 0, 0, 16'h000B); after_edge();
    drive(1, 0, 0, 0, 16'h0000); after_edge();
    dchk("clr", 4'h0, 1'b0, 4'h5, 1'b0);

    // Wrap / saturate upward from E.
    drive(0, 1, 0, 0, 16'h000E); after_edge();
    drive(0, 0, 1, 0, 16'h0000); after_edge();
    dchk("up1", 4'hF, 1'b0, 4'hF, 1'b0);
    chk("tc_at_F", 0, 16'(g_dut[0].tc_w), 16'h1);
    after_edge();
    dchk("up2", 4'h0, 1'b1, 4'hF, 1'b1);
    after_edge();
    dchk("up3", 4'h1, 1'b0, 4'hF, 1'b1);

    // Wrap / saturate downward from 1.
    drive(0, 1, 0, 0, 16'h0001); after_edge();
    drive(0, 0, 1, 1, 16'h0000); after_edge();
    dchk("dn1", 4'h0, 1'b0, 4'h0, 1'b0);
    after_edge();
    dchk("dn2", 4'hF, 1'b1, 4'h0, 1'b1);
    after_edge();
    dchk("dn3", 4'hE, 1'b0, 4'h0, 1'b1);

    // Priority at the upper bound.
    drive(0, 1, 0, 0, 16'h000F); after_edge();
    drive(1, 1, 1, 0, 16'h0007); after_edge();
    dchk("prio_clr", 4'h0, 1'b0, 4'h5, 1'b0);
    drive(0, 1, 1, 0, 16'h0007); after_edge();
    dchk("prio_load", 4'h7, 1'b0, 4'h7, 1'b0);

    // Randomised run.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r = $urandom_range(99);
      case ($urandom_range(3))
        0:       dv = 16'h0000;
        1:       dv = 16'hFFFF;
        default: dv = 16'($urandom);
      endcase
      drive(r < 2, (r >= 2) && (r < 10), $urandom_range(99) < 75,
            1'($urandom_range(1)), dv);
      if (!en && ($urandom_range(2) == 0)) down = 1'bx;
      if (!load && !clr && ($urandom_range(1) == 0)) d = 'x;
      rst_n = ($urandom_range(499) != 0);
    end

    drive(0, 0, 0, 0, 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
